// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction, ALU, condition and status codes,
// plus the E pipeline register layout and its bubble value.
package y86_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alufun_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [1:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valc;
        logic [XLEN-1:0] vala;
        logic [XLEN-1:0] valb;
        logic [3:0]      deste;
        logic [3:0]      destm;
        logic [3:0]      srca;
        logic [3:0]      srcb;
    } ereg_t;

    function automatic ereg_t bubble_value(input logic [3:0] rnone);
        ereg_t b;
        b.stat  = STAT_AOK;
        b.icode = I_NOP;
        b.ifun  = 4'h0;
        b.valc  = '0;
        b.vala  = '0;
        b.valb  = '0;
        b.deste = rnone;
        b.destm = rnone;
        b.srca  = rnone;
        b.srcb  = rnone;
        return b;
    endfunction

    localparam ereg_t E_BUBBLE = bubble_value(RNONE);

    // cc is packed {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bundle between decode/hazard logic and the execute stage. The stage is the
// slave: d_* and pipeline controls flow in; E_*, e_* and cc flow out.
interface execute_stage_if #(parameter int W = 64);

    logic [1:0]   d_stat;
    logic [3:0]   d_icode;
    logic [3:0]   d_ifun;
    logic [W-1:0] d_valC;
    logic [W-1:0] d_valA;
    logic [W-1:0] d_valB;
    logic [3:0]   d_destE;
    logic [3:0]   d_destM;
    logic [3:0]   d_srcA;
    logic [3:0]   d_srcB;
    logic         E_stall;
    logic         E_bubble;
    logic [1:0]   m_stat;
    logic [1:0]   W_stat;

    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [1:0]   E_stat;
    logic [W-1:0] E_valC;
    logic [W-1:0] E_valA;
    logic [W-1:0] E_valB;
    logic [3:0]   E_destE;
    logic [3:0]   E_destM;
    logic [3:0]   E_srcA;
    logic [3:0]   E_srcB;
    logic [W-1:0] e_valE;
    logic [3:0]   e_destE;
    logic         e_cnd;
    logic [2:0]   cc;

    modport master (
        output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_destE, d_destM, d_srcA, d_srcB,
               E_stall, E_bubble, m_stat, W_stat,
        input  E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
               E_destE, E_destM, E_srcA, E_srcB,
               e_valE, e_destE, e_cnd, cc
    );

    modport slave (
        input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_destE, d_destM, d_srcA, d_srcB,
               E_stall, E_bubble, m_stat, W_stat,
        output E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
               E_destE, E_destM, E_srcA, E_srcB,
               e_valE, e_destE, e_cnd, cc
    );

endinterface

// File: rtl/alu.sv
// Combinational Y86-64 ALU: result = b op a, with zero/sign/overflow flags.
module alu
    import y86_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  alufun_e      fun_i,
    output logic [W-1:0] result_o,
    output logic         zf_o,
    output logic         sf_o,
    output logic         of_o
);

    always_comb begin
        result_o = b_i + a_i;
        of_o     = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
        case (fun_i)
            ALU_SUB: begin
                result_o = b_i - a_i;
                of_o     = (b_i[W-1] != a_i[W-1]) && (result_o[W-1] != b_i[W-1]);
            end
            ALU_AND: begin
                result_o = b_i & a_i;
                of_o     = 1'b0;
            end
            ALU_XOR: begin
                result_o = b_i ^ a_i;
                of_o     = 1'b0;
            end
            default: ;
        endcase
    end

    assign zf_o = (result_o == '0);
    assign sf_o = result_o[W-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: D->E pipeline register, ALU operand selection,
// condition-code register and cmov/jXX condition evaluation.
module execute_stage #(
    parameter int         W     = y86_pkg::XLEN,
    parameter logic [3:0] RNONE = y86_pkg::RNONE
) (
    input  logic                clk,
    input  logic                rst_n,
    execute_stage_if.slave      bus
);

    import y86_pkg::*;

    localparam ereg_t        BUBBLE = bubble_value(RNONE);
    localparam logic [W-1:0] EIGHT  = W'(8);

    ereg_t        e_q, e_d;
    logic [2:0]   cc_q, cc_d;
    logic [W-1:0] alu_a, alu_b, alu_r;
    alufun_e      alu_fun;
    logic         alu_zf, alu_sf, alu_of;
    logic         cc_we;
    logic         cnd;

    // Bubble beats stall so the hazard unit can squash a stalled slot.
    always_comb begin
        e_d = e_q;
        if (bus.E_bubble) begin
            e_d = BUBBLE;
        end else if (!bus.E_stall) begin
            e_d.stat  = bus.d_stat;
            e_d.icode = bus.d_icode;
            e_d.ifun  = bus.d_ifun;
            e_d.valc  = bus.d_valC;
            e_d.vala  = bus.d_valA;
            e_d.valb  = bus.d_valB;
            e_d.deste = bus.d_destE;
            e_d.destm = bus.d_destM;
            e_d.srca  = bus.d_srcA;
            e_d.srcb  = bus.d_srcB;
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (e_q.icode)
            I_RRMOVQ, I_OPQ:                alu_a = e_q.vala;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = e_q.valc;
            I_CALL, I_PUSHQ:                alu_a = -EIGHT;
            I_RET, I_POPQ:                  alu_a = EIGHT;
            default:                        alu_a = '0;
        endcase
        case (e_q.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:         alu_b = e_q.valb;
            default:                        alu_b = '0;
        endcase
    end

    assign alu_fun = (e_q.icode == I_OPQ) ? alufun_e'(e_q.ifun) : ALU_ADD;

    alu #(.W(W)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .fun_i    (alu_fun),
        .result_o (alu_r),
        .zf_o     (alu_zf),
        .sf_o     (alu_sf),
        .of_o     (alu_of)
    );

    // A faulting instruction downstream must not leave its OPQ successors' flags behind.
    assign cc_we = (e_q.icode == I_OPQ) && (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK);
    assign cc_d  = cc_we ? {alu_zf, alu_sf, alu_of} : cc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q  <= BUBBLE;
            cc_q <= 3'b100;
        end else begin
            e_q  <= e_d;
            cc_q <= cc_d;
        end
    end

    assign cnd = cond_eval(e_q.ifun, cc_q);

    assign bus.e_cnd   = ((e_q.icode == I_RRMOVQ) || (e_q.icode == I_JXX)) ? cnd : 1'b0;
    assign bus.e_destE = ((e_q.icode == I_RRMOVQ) && !bus.e_cnd) ? RNONE : e_q.deste;
    assign bus.e_valE  = alu_r;
    assign bus.cc      = cc_q;

    assign bus.E_stat  = e_q.stat;
    assign bus.E_icode = e_q.icode;
    assign bus.E_ifun  = e_q.ifun;
    assign bus.E_valC  = e_q.valc;
    assign bus.E_valA  = e_q.vala;
    assign bus.E_valB  = e_q.valb;
    assign bus.E_destE = e_q.deste;
    assign bus.E_destM = e_q.destm;
    assign bus.E_srcA  = e_q.srca;
    assign bus.E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the Y86-64 execute semantics.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    execute_stage_if #(.W(64)) bus ();

    execute_stage #(.W(64), .RNONE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the instruction sitting in E and the flag register.
    logic [1:0]  m_stat;
    logic [3:0]  m_icode, m_ifun, m_destE, m_destM, m_srcA, m_srcB;
    logic [63:0] m_valC, m_valA, m_valB;
    logic [2:0]  m_cc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Executes one instruction the way the ISA describes it.
    task automatic ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                            output logic [63:0] r, output logic [2:0] flags);
        logic [63:0] opa, opb;
        logic [64:0] wide;
        logic        of;
        int          op;
        if (ic == 4'h2 || ic == 4'h6)                    opa = va;
        else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) opa = vc;
        else if (ic == 4'h8 || ic == 4'hA)               opa = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic == 4'h9 || ic == 4'hB)               opa = 64'd8;
        else                                             opa = 64'd0;
        opb = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? vb : 64'd0;
        op  = (ic == 4'h6) ? int'(fn) : 0;
        of  = 1'b0;
        if (op == 1) begin
            wide = {opb[63], opb} - {opa[63], opa};
            r    = wide[63:0];
            of   = wide[64] ^ wide[63];
        end else if (op == 2) begin
            r = opb & opa;
        end else if (op == 3) begin
            r = opb ^ opa;
        end else begin
            wide = {opb[63], opb} + {opa[63], opa};
            r    = wide[63:0];
            of   = wide[64] ^ wide[63];
        end
        flags = {(r == 64'd0), r[63], of};
    endtask

    function automatic logic ref_cond(input logic [3:0] fn, input logic [2:0] f);
        logic less;
        less = f[1] ^ f[0];
        case (fn)
            4'h0: return 1'b1;
            4'h1: return less | f[2];
            4'h2: return less;
            4'h3: return f[2];
            4'h4: return !f[2];
            4'h5: return !less;
            4'h6: return !less && !f[2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_stat = 2'd0; m_icode = 4'h1; m_ifun = 4'h0;
        m_valC = 64'd0; m_valA = 64'd0; m_valB = 64'd0;
        m_destE = 4'hF; m_destM = 4'hF; m_srcA = 4'hF; m_srcB = 4'hF;
        m_cc = 3'b100;
    endtask

    task automatic model_check(input string tag);
        logic [63:0] r;
        logic [2:0]  fl;
        logic        c;
        ref_exec(m_icode, m_ifun, m_valC, m_valA, m_valB, r, fl);
        c = (m_icode == 4'h2 || m_icode == 4'h7) ? ref_cond(m_ifun, m_cc) : 1'b0;
        chk({tag, ".E_stat"},  bus.E_stat,  m_stat);
        chk({tag, ".E_icode"}, bus.E_icode, m_icode);
        chk({tag, ".E_ifun"},  bus.E_ifun,  m_ifun);
        chk({tag, ".E_valC"},  bus.E_valC,  m_valC);
        chk({tag, ".E_valA"},  bus.E_valA,  m_valA);
        chk({tag, ".E_valB"},  bus.E_valB,  m_valB);
        chk({tag, ".E_destE"}, bus.E_destE, m_destE);
        chk({tag, ".E_destM"}, bus.E_destM, m_destM);
        chk({tag, ".E_srcA"},  bus.E_srcA,  m_srcA);
        chk({tag, ".E_srcB"},  bus.E_srcB,  m_srcB);
        chk({tag, ".e_valE"},  bus.e_valE,  r);
        chk({tag, ".e_cnd"},   bus.e_cnd,   c);
        chk({tag, ".e_destE"}, bus.e_destE, (m_icode == 4'h2 && !c) ? 4'hF : m_destE);
        chk({tag, ".cc"},      bus.cc,      m_cc);
    endtask

    // One rising edge: model advances from the inputs driven this cycle.
    task automatic tick(input string tag);
        logic [63:0] r;
        logic [2:0]  fl;
        logic [2:0]  ncc;
        ref_exec(m_icode, m_ifun, m_valC, m_valA, m_valB, r, fl);
        ncc = (m_icode == 4'h6 && bus.m_stat == 2'd0 && bus.W_stat == 2'd0) ? fl : m_cc;
        @(posedge clk);
        #1;
        m_cc = ncc;
        if (bus.E_bubble) begin
            m_stat = 2'd0; m_icode = 4'h1; m_ifun = 4'h0;
            m_valC = 64'd0; m_valA = 64'd0; m_valB = 64'd0;
            m_destE = 4'hF; m_destM = 4'hF; m_srcA = 4'hF; m_srcB = 4'hF;
        end else if (!bus.E_stall) begin
            m_stat = bus.d_stat; m_icode = bus.d_icode; m_ifun = bus.d_ifun;
            m_valC = bus.d_valC; m_valA = bus.d_valA; m_valB = bus.d_valB;
            m_destE = bus.d_destE; m_destM = bus.d_destM;
            m_srcA = bus.d_srcA; m_srcB = bus.d_srcB;
        end
        model_check(tag);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                         input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
        bus.d_stat   = 2'd0;
        bus.d_icode  = ic;
        bus.d_ifun   = fn;
        bus.d_valC   = vc;
        bus.d_valA   = va;
        bus.d_valB   = vb;
        bus.d_destE  = de;
        bus.d_destM  = 4'($urandom_range(0, 15));
        bus.d_srcA   = 4'($urandom_range(0, 15));
        bus.d_srcB   = 4'($urandom_range(0, 15));
        bus.E_stall  = 1'b0;
        bus.E_bubble = 1'b0;
        bus.m_stat   = 2'd0;
        bus.W_stat   = 2'd0;
    endtask

    task automatic nop();
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd3, 4'h4);
        #12;
        model_reset();
        chk("reset.E_icode", bus.E_icode, 64'h1);
        chk("reset.E_destE", bus.E_destE, 64'hF);
        chk("reset.e_destE", bus.e_destE, 64'hF);
        chk("reset.cc",      bus.cc,      64'h4);
        chk("reset.e_cnd",   bus.e_cnd,   64'h0);
        model_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive(4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h3);
        tick("add");
        chk("add.valE", bus.e_valE, 64'd12);
        chk("add.destE", bus.e_destE, 64'h3);
        nop();
        tick("add_cc");
        chk("add.cc", bus.cc, 64'h0);

        drive(4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h4);
        tick("sub_ovf");
        chk("sub_ovf.valE", bus.e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        nop();
        tick("sub_ovf_cc");
        chk("sub_ovf.cc", bus.cc, 64'h1);

        drive(4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h3);
        tick("add2");
        nop();
        tick("add2_cc");
        drive(4'h2, 4'h1, 64'd0, 64'h55, 64'd0, 4'h2);
        tick("cmovle_nt");
        chk("cmovle_nt.cnd", bus.e_cnd, 64'h0);
        chk("cmovle_nt.destE", bus.e_destE, 64'hF);

        drive(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h5);
        tick("xor_zero");
        nop();
        tick("xor_zero_cc");
        chk("xor_zero.cc", bus.cc, 64'h4);
        drive(4'h2, 4'h1, 64'd0, 64'h55, 64'd0, 4'h2);
        tick("cmovle_t");
        chk("cmovle_t.cnd", bus.e_cnd, 64'h1);
        chk("cmovle_t.destE", bus.e_destE, 64'h2);
        chk("cmovle_t.valE", bus.e_valE, 64'h55);

        drive(4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h3);
        tick("add3");
        drive(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h5);
        tick("xor_sup");
        chk("xor_sup.valE", bus.e_valE, 64'd0);
        nop();
        bus.m_stat = 2'd2;
        tick("xor_sup_m");
        chk("xor_sup_m.cc", bus.cc, 64'h0);
        drive(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h5);
        tick("xor_sup2");
        nop();
        bus.W_stat = 2'd1;
        tick("xor_sup_w");
        chk("xor_sup_w.cc", bus.cc, 64'h0);
        drive(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h5);
        tick("xor_wr");
        nop();
        tick("xor_wr_cc");
        chk("xor_wr.cc", bus.cc, 64'h4);

        drive(4'h3, 4'h0, 64'hABC, 64'd0, 64'd0, 4'h6);
        tick("irmov");
        for (int k = 0; k < 2; k++) begin
            drive(4'h6, 4'h1, 64'($urandom()), 64'($urandom()), 64'($urandom()), 4'h1);
            bus.E_stall = 1'b1;
            tick("stall");
            chk("stall.icode", bus.E_icode, 64'h3);
            chk("stall.valC", bus.E_valC, 64'hABC);
        end
        drive(4'h3, 4'h0, 64'h123, 64'd0, 64'd0, 4'h6);
        bus.E_bubble = 1'b1;
        tick("bubble");
        chk("bubble.icode", bus.E_icode, 64'h1);
        chk("bubble.destE", bus.E_destE, 64'hF);
        drive(4'h3, 4'h0, 64'h77, 64'd0, 64'd0, 4'h6);
        tick("irmov2");
        drive(4'h5, 4'h0, 64'h88, 64'd0, 64'd1, 4'h7);
        bus.E_stall  = 1'b1;
        bus.E_bubble = 1'b1;
        tick("stall_bubble");
        chk("stall_bubble.icode", bus.E_icode, 64'h1);

        drive(4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4);
        tick("pushq");
        chk("pushq.valE", bus.e_valE, 64'hF8);
        drive(4'hB, 4'h0, 64'd0, 64'd0, 64'hF8, 4'h4);
        tick("popq");
        chk("popq.valE", bus.e_valE, 64'h100);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  ic;
            logic [63:0] va, vb;
            ic = 4'($urandom_range(0, 11));
            va = {$urandom(), $urandom()};
            vb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) va[62:0] = 63'd0;
            if ($urandom_range(0, 3) == 0) vb = va;
            drive(ic, (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                  {$urandom(), $urandom()}, va, vb, 4'($urandom_range(0, 15)));
            bus.d_stat   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.E_stall  = ($urandom_range(0, 7) == 0);
            bus.E_bubble = ($urandom_range(0, 9) == 0);
            bus.m_stat   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.W_stat   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (i == 150) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("async_rst.icode", bus.E_icode, 64'h1);
                chk("async_rst.cc", bus.cc, 64'h4);
                model_check("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
